// File: rtl/lite_16_pkg.sv
// lite_16_pkg: shared lite_16 run-control state encodings and state decode helpers
package lite_16_pkg;
  localparam logic [2:0] st_idle     = 3'd0;
  localparam logic [2:0] st_rst_hold = 3'd1;
  localparam logic [2:0] st_run      = 3'd2;
  localparam logic [2:0] st_paused   = 3'd3;
  localparam logic [2:0] st_step     = 3'd4;
  localparam logic [2:0] st_halted   = 3'd5;
  localparam logic [2:0] st_timeout  = 3'd6;
  function automatic logic holds_rst(input logic [2:0] s);
    return s == st_idle || s == st_rst_hold;
  endfunction
  function automatic logic clocks_core(input logic [2:0] s);
    return s == st_run || s == st_step;
  endfunction
  function automatic logic is_done(input logic [2:0] s);
    return s == st_halted || s == st_timeout;
  endfunction
endpackage

// File: rtl/lite_16_hold_counter.sv
// lite_16_hold_counter: loadable down-counter with zero flag
module lite_16_hold_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (!rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && !zero) cnt <= cnt - W'(1);
  assign zero = cnt == '0;
endmodule

// File: rtl/lite_16_run_ctrl.sv
// lite_16_run_ctrl: run/step/breakpoint/timeout controller for the lite_16 core
module lite_16_run_ctrl
  import lite_16_pkg::*;
#(
  parameter int PC_WIDTH       = 16,
  parameter int CNT_WIDTH      = 32,
  parameter int RST_CYCLES     = 1,
  parameter int TIMEOUT_CYCLES = 50
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 step_mode,
  input  logic                 step_req,
  input  logic                 halt_in,
  input  logic [PC_WIDTH-1:0]  pc,
  input  logic                 bp_en,
  input  logic [PC_WIDTH-1:0]  bp_addr,
  output logic                 cpu_rst,
  output logic                 cpu_clk_en,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic                 done,
  output logic                 timed_out,
  output logic                 bp_hit,
  output logic [2:0]           state
);
  logic [2:0] nxt;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic active, go, hit_bp, hit_to, hold_zero;
  assign active  = clocks_core(state);
  assign go      = start && !abort && (state == st_idle || is_done(state));
  assign cnt_inc = &cycle_count ? cycle_count : cycle_count + CNT_WIDTH'(1);
  assign hit_bp  = bp_en && pc == bp_addr;
  assign hit_to  = TIMEOUT_CYCLES != 0 && cnt_inc == CNT_WIDTH'(TIMEOUT_CYCLES);
  // holds RST_CYCLES-1 so the zero flag marks the last reset-hold cycle
  lite_16_hold_counter #(.W(CNT_WIDTH)) u_hold (
    .clk(clk),
    .rst(rst),
    .load(go),
    .load_val(CNT_WIDTH'(RST_CYCLES - 1)),
    .dec(state == st_rst_hold),
    .zero(hold_zero)
  );
  always_comb begin
    nxt = state;
    case (state)
      st_rst_hold: nxt = hold_zero ? (step_mode ? st_paused : st_run) : st_rst_hold;
      st_run, st_step: nxt = halt_in || hit_bp ? st_halted :
                             hit_to ? st_timeout :
                             state == st_step || step_mode ? st_paused : st_run;
      st_paused: nxt = step_req ? st_step : step_mode ? st_paused : st_run;
      default: nxt = state;
    endcase
    if (go) nxt = st_rst_hold;
    if (abort) nxt = st_idle;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state       <= st_idle;
      cpu_rst     <= 1'b1;
      cpu_clk_en  <= 1'b0;
      done        <= 1'b0;
      cycle_count <= '0;
      timed_out   <= 1'b0;
      bp_hit      <= 1'b0;
    end else begin
      state       <= nxt;
      cpu_rst     <= holds_rst(nxt);
      cpu_clk_en  <= clocks_core(nxt);
      done        <= is_done(nxt);
      cycle_count <= go ? '0 : active && !abort ? cnt_inc : cycle_count;
      timed_out   <= !(abort || go) && (timed_out || nxt == st_timeout);
      bp_hit      <= !(abort || go) && (bp_hit || active && nxt == st_halted && !halt_in);
    end
endmodule

// File: tb/tb_lite_16_run_ctrl.sv
// tb_lite_16_run_ctrl: directed and random checks of lite_16_run_ctrl against a reference model
module tb_lite_16_run_ctrl;
  localparam int RC = 3;
  localparam int TO = 50;
  localparam int S_IDLE = 0, S_HOLD = 1, S_RUN = 2, S_PAUSE = 3, S_STEP = 4, S_HALT = 5, S_TOUT = 6;
  logic clk = 0, rst = 0, start = 0, abort = 0, step_mode = 0, step_req = 0, halt_in = 0, bp_en = 0;
  logic [15:0] pc = 0, bp_addr = 0;
  logic cpu_rst, cpu_clk_en, done, timed_out, bp_hit;
  logic [31:0] cycle_count;
  logic [2:0] state;
  int n_chk = 0, n_fail = 0;
  int m_state = S_IDLE, m_hold = 0, m_to = 0, m_bp = 0;
  longint m_cnt = 0;
  int n_rst = 0, n_en = 0;
  always #5 clk = ~clk;
  lite_16_run_ctrl #(.PC_WIDTH(16), .CNT_WIDTH(32), .RST_CYCLES(RC), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .step_mode(step_mode),
    .step_req(step_req), .halt_in(halt_in), .pc(pc), .bp_en(bp_en), .bp_addr(bp_addr),
    .cpu_rst(cpu_rst), .cpu_clk_en(cpu_clk_en), .cycle_count(cycle_count), .done(done),
    .timed_out(timed_out), .bp_hit(bp_hit), .state(state)
  );
  task automatic chk(string tag, string what, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s.%s: observed %0h expected %0h", tag, what, got, exp);
    end
  endtask
  // one rising edge of the spec's behaviour, applied to the abstract model
  task automatic model_step();
    int s = m_state;
    if (!rst) begin
      m_state = S_IDLE; m_cnt = 0; m_to = 0; m_bp = 0;
    end else if (abort) begin
      m_state = S_IDLE; m_to = 0; m_bp = 0;
    end else if (start && (s == S_IDLE || s == S_HALT || s == S_TOUT)) begin
      m_state = S_HOLD; m_cnt = 0; m_to = 0; m_bp = 0; m_hold = RC;
    end else if (s == S_HOLD) begin
      m_hold--;
      if (m_hold == 0) m_state = step_mode ? S_PAUSE : S_RUN;
    end else if (s == S_RUN || s == S_STEP) begin
      if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
      if (halt_in) m_state = S_HALT;
      else if (bp_en && pc == bp_addr) begin m_state = S_HALT; m_bp = 1; end
      else if (TO != 0 && m_cnt == TO) begin m_state = S_TOUT; m_to = 1; end
      else m_state = (s == S_STEP || step_mode) ? S_PAUSE : S_RUN;
    end else if (s == S_PAUSE) begin
      m_state = step_req ? S_STEP : step_mode ? S_PAUSE : S_RUN;
    end
  endtask
  task automatic check_all(string tag);
    chk(tag, "state", state, m_state);
    chk(tag, "cpu_rst", cpu_rst, m_state == S_IDLE || m_state == S_HOLD);
    chk(tag, "cpu_clk_en", cpu_clk_en, m_state == S_RUN || m_state == S_STEP);
    chk(tag, "done", done, m_state == S_HALT || m_state == S_TOUT);
    chk(tag, "cycle_count", cycle_count, m_cnt);
    chk(tag, "timed_out", timed_out, m_to);
    chk(tag, "bp_hit", bp_hit, m_bp);
  endtask
  task automatic tick(string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
    n_rst += int'(cpu_rst === 1'b1);
    n_en += int'(cpu_clk_en === 1'b1);
  endtask
  initial begin
    tick("reset");
    tick("reset");
    rst = 1;
    tick("idle");
    // free run into the timeout budget
    n_rst = 0; n_en = 0;
    start = 1; tick("a_start"); start = 0;
    for (int i = 0; i < 200 && m_state != S_TOUT; i++) begin
      pc = 16'($urandom);
      tick("a_run");
    end
    chk("a", "rst_cycles", n_rst, RC);
    chk("a", "en_cycles", n_en, TO);
    chk("a", "final_state", state, S_TOUT);
    chk("a", "final_count", cycle_count, TO);
    chk("a", "final_timed_out", timed_out, 1);
    chk("a", "final_done", done, 1);
    // restart from TIMEOUT, halt after ten run cycles, stray start ignored
    n_en = 0;
    start = 1; tick("b_start"); start = 0;
    for (int i = 0; i < 100 && m_state != S_HALT; i++) begin
      halt_in = cycle_count == 9 && state == 3'(S_RUN);
      start = cycle_count == 3;
      tick("b_run");
    end
    halt_in = 0; start = 0;
    chk("b", "final_state", state, S_HALT);
    chk("b", "final_count", cycle_count, 10);
    chk("b", "en_cycles", n_en, 10);
    chk("b", "final_timed_out", timed_out, 0);
    // breakpoint and halt on the same cycle: halt wins
    bp_en = 1; bp_addr = 16'h0006;
    start = 1; tick("c1_start"); start = 0;
    for (int i = 0; i < 100 && m_state != S_HALT; i++) begin
      pc = (cycle_count == 5 && state == 3'(S_RUN)) ? 16'h0006 : 16'($urandom_range(7, 500));
      halt_in = pc == 16'h0006;
      tick("c1_run");
    end
    halt_in = 0;
    chk("c1", "final_state", state, S_HALT);
    chk("c1", "final_bp_hit", bp_hit, 0);
    chk("c1", "final_count", cycle_count, 6);
    // breakpoint alone
    start = 1; tick("c2_start"); start = 0;
    for (int i = 0; i < 100 && m_state != S_HALT; i++) begin
      pc = (cycle_count == 7 && state == 3'(S_RUN)) ? 16'h0006 : 16'($urandom_range(7, 500));
      tick("c2_run");
    end
    bp_en = 0;
    chk("c2", "final_state", state, S_HALT);
    chk("c2", "final_bp_hit", bp_hit, 1);
    chk("c2", "final_count", cycle_count, 8);
    // single stepping
    step_mode = 1;
    start = 1; tick("d_start"); start = 0;
    n_en = 0;
    for (int k = 0; k < 3; k++) begin
      repeat (5) tick("d_wait");
      step_req = 1; tick("d_step"); step_req = 0;
    end
    repeat (3) tick("d_tail");
    chk("d", "en_pulses", n_en, 3);
    chk("d", "final_count", cycle_count, 3);
    chk("d", "final_state", state, S_PAUSE);
    // abort at cycle 20 holds the count
    step_mode = 0;
    for (int i = 0; i < 100 && cycle_count != 20; i++) tick("e1_run");
    abort = 1; tick("e1_abort"); abort = 0;
    chk("e1", "state", state, S_IDLE);
    chk("e1", "cpu_rst", cpu_rst, 1);
    chk("e1", "count_held", cycle_count, 20);
    // reset at cycle 20 clears the count
    start = 1; tick("e2_start"); start = 0;
    for (int i = 0; i < 100 && cycle_count != 20; i++) tick("e2_run");
    rst = 0; tick("e2_rst"); rst = 1;
    chk("e2", "state", state, S_IDLE);
    chk("e2", "cpu_rst", cpu_rst, 1);
    chk("e2", "count_cleared", cycle_count, 0);
    // random traffic against the model
    for (int i = 0; i < 800; i++) begin
      rst = $urandom_range(0, 149) != 0;
      start = $urandom_range(0, 11) == 0;
      abort = $urandom_range(0, 59) == 0;
      if ($urandom_range(0, 19) == 0) step_mode = ~step_mode;
      step_req = $urandom_range(0, 2) == 0;
      halt_in = $urandom_range(0, 79) == 0;
      bp_en = 1'($urandom);
      bp_addr = 16'($urandom_range(0, 31));
      pc = 16'($urandom_range(0, 31));
      tick("rand");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/lite_16_run_ctrl.md
LITE_16_RUN_CTRL -- requirements
Module: lite_16_run_ctrl

Interface
REQ-001 SHALL have parameter PC_WIDTH, 16: width of pc and bp_addr.
REQ-002 SHALL have parameter CNT_WIDTH, 32: width of cycle_count.
REQ-003 SHALL have parameter RST_CYCLES, 1: cycles cpu_rst is held after start, legal range 1..2^CNT_WIDTH-1.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, 50: run-cycle budget; 0 disables timeout.
REQ-005 SHALL have port clk, input, 1: sole clock, all logic on rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-low.
REQ-007 SHALL have port start, input, 1: begin a run from IDLE.
REQ-008 SHALL have port abort, input, 1: return to IDLE from any state.
REQ-009 SHALL have port step_mode, input, 1: level; pause the core and allow single steps.
REQ-010 SHALL have port step_req, input, 1: one-cycle pulse; advance core one cycle while PAUSED.
REQ-011 SHALL have port halt_in, input, 1: core reports halt.
REQ-012 SHALL have port pc, input, PC_WIDTH: current core program counter.
REQ-013 SHALL have port bp_en, input, 1 and bp_addr, input, PC_WIDTH: breakpoint enable and address.
REQ-014 SHALL have port cpu_rst, output, 1: active-high reset to the lite_16 core.
REQ-015 SHALL have port cpu_clk_en, output, 1: core clock enable.
REQ-016 SHALL have ports cycle_count, output, CNT_WIDTH; done, output, 1; timed_out, output, 1; bp_hit, output, 1; state, output, 3.

Function
REQ-017 SHALL implement states IDLE, RST_HOLD, RUN, PAUSED, STEP, HALTED, TIMEOUT; all outputs registered, decoded from state.
REQ-018 SHALL drive cpu_rst=1 in IDLE and RST_HOLD, 0 elsewhere; cpu_clk_en=1 only in RUN and STEP.
REQ-019 SHALL go IDLE->RST_HOLD on start, clearing cycle_count, timed_out, bp_hit and loading hold counter with RST_CYCLES.
REQ-020 SHALL stay in RST_HOLD exactly RST_CYCLES cycles, then enter PAUSED if step_mode=1, else RUN.
REQ-021 SHALL increment cycle_count by 1 for each cycle cpu_clk_en=1, saturating at 2^CNT_WIDTH-1.
REQ-022 SHALL, in RUN or STEP, evaluate exits with priority halt_in > breakpoint (bp_en and pc==bp_addr) > timeout (TIMEOUT_CYCLES!=0 and incremented count==TIMEOUT_CYCLES); targets HALTED, HALTED with bp_hit=1, TIMEOUT with timed_out=1.
REQ-023 SHALL, with no exit, go RUN->PAUSED when step_mode=1 and PAUSED->RUN when step_mode=0.
REQ-024 SHALL go PAUSED->STEP on step_req; STEP lasts exactly one cycle then returns to PAUSED unless an exit fires; step_req outside PAUSED is ignored.
REQ-025 SHALL assert done=1 in HALTED and TIMEOUT; these states hold until abort or start (start re-enters RST_HOLD).
REQ-026 SHALL give abort priority over every other input: next state IDLE, sticky flags cleared, cycle_count held.
REQ-027 SHALL treat start outside IDLE/HALTED/TIMEOUT as ignored; simultaneous start and abort -> IDLE.

Reset
REQ-028 SHALL, when rst=0 at a rising edge, enter IDLE with cpu_rst=1, cpu_clk_en=0, cycle_count=0, done=0, timed_out=0, bp_hit=0, state=IDLE encoding, including mid-run.

Structure
REQ-029 SHALL take state encodings (IDLE=0 .. TIMEOUT=6) from the shared lite_16 definitions package/header, exported for benches.
REQ-030 SHALL instantiate one sub-module lite_16_hold_counter (loadable down-counter with zero flag) for RST_HOLD timing.

Verification
REQ-031 Defaults, start pulse, halt_in never set -> cpu_rst high 1 cycle, 50 cycles cpu_clk_en, then TIMEOUT, timed_out=1, cycle_count=50, done=1.
REQ-032 RST_CYCLES=4, halt_in raised after 10 run cycles -> cpu_rst high 4 cycles, HALTED, cycle_count=10, timed_out=0.
REQ-033 bp_en=1, bp_addr=0x0006, pc reaches 0x0006 same cycle halt_in=1 -> HALTED, bp_hit=0 (halt priority).
REQ-034 step_mode=1, three step_req pulses 5 cycles apart -> exactly three single-cycle cpu_clk_en pulses, cycle_count=3, state PAUSED.
REQ-035 rst=0 mid-RUN at cycle 20, and separately abort at cycle 20 -> IDLE next edge, cpu_rst=1; reset clears cycle_count to 0, abort holds 20.
